varint_field_serializer: RTL

Downstream consumer of the object buffer's output entry stream. For each accepted table entry it fetches the field value from the C++ object in memory at cpp_base_addr + offset, encodes a protobuf tag varint followed by a value varint, and emits the result as a byte stream. It drives the ser_ready/ser_done handshake back to the object buffer, one entry at a time.

---
 rtl/varint_field_serializer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/varint_field_serializer.sv
// Fetches one field per table entry and emits it as a protobuf tag varint followed by a value varint.
// Optional: define VARINT_ZIGZAG_EN to encode field_type 2 as zigzag sint64; otherwise it is encoded as uint64.
module varint_field_serializer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    // in_entry packing: [95:67] field_id, [66:3] offset, [2] nested, [1:0] field_type
    input  logic [95:0]      in_entry,
    input  logic             in_entry_valid,
    input  logic [63:0]      cpp_base_addr,
    output logic             ser_ready,
    output logic             ser_done,
    output logic             mem_req_valid,
    output logic [63:0]      mem_req_addr,
    input  logic             mem_req_ready,
    input  logic             mem_resp_valid,
    input  logic [63:0]      mem_resp_data,
    output logic [7:0]       out_byte,
    output logic             out_byte_valid,
    input  logic             out_byte_ready,
    output logic [CNT_W-1:0] bytes_emitted,
    output logic             err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEM_REQ,
        ST_MEM_WAIT,
        ST_EMIT,
        ST_DONE
    } state_t;

    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : TIMEOUT_CYCLES - 32'd1;

    state_t            r_state;
    state_t            w_state_next;
    logic [63:0]       r_addr;
    logic [28:0]       r_field_id;
    logic [1:0]        r_field_type;
    logic [31:0]       r_wait_cnt;
    logic [31:0]       r_tag;
    logic [63:0]       r_val;
    logic              r_in_tag;
    logic [CNT_W-1:0]  r_bytes;
    logic              r_err;

    logic [28:0]       w_field_id;
    logic [63:0]       w_offset;
    logic              w_nested;
    logic [1:0]        w_field_type;
    logic              w_accept;
    logic              w_xfer;
    logic              w_timeout;
    logic [63:0]       w_cond_val;
    logic [63:0]       w_cur;
    logic [63:0]       w_rest;
    logic              w_last;

    assign w_field_id   = in_entry[95:67];
    assign w_offset     = in_entry[66:3];
    assign w_nested     = in_entry[2];
    assign w_field_type = in_entry[1:0];

    assign w_accept  = (r_state == ST_IDLE) && in_entry_valid;
    assign w_xfer    = out_byte_valid && out_byte_ready;
    assign w_timeout = TO_EN && (r_wait_cnt == TO_LAST);

    always_comb begin
        case (r_field_type)
            2'd1:    w_cond_val = {32'd0, mem_resp_data[31:0]};
`ifdef VARINT_ZIGZAG_EN
            2'd2:    w_cond_val = {mem_resp_data[62:0], 1'b0} ^ {64{mem_resp_data[63]}};
`else
            2'd2:    w_cond_val = mem_resp_data;
`endif
            2'd3:    w_cond_val = {63'd0, mem_resp_data[0]};
            default: w_cond_val = mem_resp_data;
        endcase
    end

    // The active varint is whichever shift register is being drained; the
    // continuation bit is set while anything remains above the current group.
    assign w_cur  = r_in_tag ? {32'd0, r_tag} : r_val;
    assign w_rest = w_cur >> 7;
    assign w_last = (w_rest == 64'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        ser_ready      = 1'b0;
        ser_done       = 1'b0;
        mem_req_valid  = 1'b0;
        mem_req_addr   = 64'd0;
        out_byte       = 8'd0;
        out_byte_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ser_ready = 1'b1;
                if (in_entry_valid) begin
                    w_state_next = w_nested ? ST_DONE : ST_MEM_REQ;
                end
            end
            ST_MEM_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = r_addr;
                if (mem_req_ready) begin
                    w_state_next = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_resp_valid) begin
                    w_state_next = ST_EMIT;
                end else if (w_timeout) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_EMIT: begin
                out_byte_valid = 1'b1;
                out_byte       = {~w_last, w_cur[6:0]};
                if (out_byte_ready && !r_in_tag && w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                ser_done     = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_addr       <= 64'd0;
            r_field_id   <= 29'd0;
            r_field_type <= 2'd0;
            r_wait_cnt   <= 32'd0;
            r_tag        <= 32'd0;
            r_val        <= 64'd0;
            r_in_tag     <= 1'b0;
            r_bytes      <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr       <= cpp_base_addr + w_offset;
                r_field_id   <= w_field_id;
                r_field_type <= w_field_type;
            end

            if (r_state == ST_MEM_REQ) begin
                r_wait_cnt <= 32'd0;
            end else if (r_state == ST_MEM_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 32'd1;
            end

            if (r_state == ST_MEM_WAIT && mem_resp_valid) begin
                r_tag    <= {r_field_id, 3'b000};
                r_val    <= w_cond_val;
                r_in_tag <= 1'b1;
            end else if (w_xfer) begin
                if (r_in_tag) begin
                    if (w_last) begin
                        r_in_tag <= 1'b0;
                    end else begin
                        r_tag <= w_rest[31:0];
                    end
                end else begin
                    r_val <= w_rest;
                end
            end

            if (w_xfer) begin
                r_bytes <= r_bytes + {{(CNT_W-1){1'b0}}, 1'b1};
            end

            if (r_state == ST_MEM_WAIT && !mem_resp_valid && w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bytes_emitted = r_bytes;
    assign err           = r_err;

endmodule
